// File: rtl/calc_sched_pkg.sv
// calc_sched_pkg: shared widths and FSM state type for the calc_sched scheduler.
package calc_sched_pkg;
   localparam int NUM_W   = 4;
   localparam int MODE_W  = 2;
   localparam int RES_W   = 7;
   localparam int NUM_REQ = 2;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ISSUE,
      WAIT,
      RESP
   } sched_state_e;
endpackage

// File: rtl/calc_sched_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter. The pointer names the requester with priority;
// after a served job it moves to the requester following the one just served.
module rr_arb2
   import calc_sched_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               upd,
   input  logic               upd_id,
   output logic [NUM_REQ-1:0] grant
);
   logic ptr_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_reg <= 1'b0;
      end else if (upd) begin
         ptr_reg <= ~upd_id;
      end
   end

   // A requester wins if it holds priority, or if the priority holder is not asking.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
      assign grant[gi] = req[gi] && ((ptr_reg == 1'(gi)) || !req[ptr_reg]);
   end
endmodule

// File: rtl/calc_sched.sv
// calc_sched: round-robin scheduler sharing one nibble-stream engine between two requesters.
// Define CALC_SCHED_TIMEOUT_EN to enable the WAIT-state watchdog (TIMEOUT_CYCLES).
module calc_sched
   import calc_sched_pkg::*;
#(
   parameter int BURST_LEN      = 6,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ-1:0][MODE_W-1:0] req_mode,
   input  logic [NUM_REQ-1:0][NUM_W-1:0]  req_data,
   output logic [NUM_REQ-1:0]             gnt,
   output logic                           eng_in_valid,
   output logic [NUM_W-1:0]               eng_in_number,
   output logic [MODE_W-1:0]              eng_mode,
   input  logic                           eng_out_valid,
   input  logic signed [RES_W-1:0]        eng_out_result,
   output logic                           rsp_valid,
   output logic                           rsp_id,
   output logic signed [RES_W-1:0]        rsp_result,
   output logic                           rsp_err,
   input  logic                           rsp_ready
);
   localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);

   sched_state_e            state_reg, state_next;
   logic [NUM_REQ-1:0]      gnt_reg, gnt_next;
   logic                    id_reg, id_next;
   logic [MODE_W-1:0]       mode_reg, mode_next;
   logic [CNT_W-1:0]        beat_reg, beat_next;
   logic [CNT_W-1:0]        issue_reg, issue_next;
   logic                    eng_in_valid_reg, eng_in_valid_next;
   logic [NUM_W-1:0]        eng_in_number_reg, eng_in_number_next;
   logic [MODE_W-1:0]       eng_mode_reg, eng_mode_next;
   logic                    rsp_valid_reg, rsp_valid_next;
   logic                    rsp_id_reg, rsp_id_next;
   logic signed [RES_W-1:0] rsp_result_reg, rsp_result_next;
   logic                    beat_acc;
   logic                    arb_upd;
   logic [NUM_REQ-1:0]      arb_gnt;
   logic [CNT_W-1:0]        rd_idx;
   logic [NUM_W-1:0]        buf_mem [BURST_LEN];

`ifdef CALC_SCHED_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] wait_cnt_reg, wait_cnt_next;
   logic            rsp_err_reg, rsp_err_next;
`endif

   rr_arb2 u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req_valid),
      .upd    (arb_upd),
      .upd_id (id_reg),
      .grant  (arb_gnt)
   );

   // Burst buffer; contents are don't-care until written, so it carries no reset.
   always_ff @(posedge clk) begin
      if (beat_acc) begin
         buf_mem[beat_reg] <= req_data[id_reg];
      end
   end

   always_comb begin
      state_next         = state_reg;
      gnt_next           = gnt_reg;
      id_next            = id_reg;
      mode_next          = mode_reg;
      beat_next          = beat_reg;
      issue_next         = issue_reg;
      eng_in_valid_next  = 1'b0;
      eng_in_number_next = '0;
      eng_mode_next      = '0;
      rsp_valid_next     = rsp_valid_reg;
      rsp_id_next        = rsp_id_reg;
      rsp_result_next    = rsp_result_reg;
      beat_acc           = 1'b0;
      arb_upd            = 1'b0;
      rd_idx             = '0;
`ifdef CALC_SCHED_TIMEOUT_EN
      rsp_err_next       = rsp_err_reg;
      wait_cnt_next      = (state_reg == WAIT) ? wait_cnt_reg + 1'b1 : '0;
`endif
      case (state_reg)
         IDLE: begin
            if (|req_valid) begin
               gnt_next   = arb_gnt;
               id_next    = arb_gnt[1];
               beat_next  = '0;
               state_next = LOAD;
            end
         end
         LOAD: begin
            if (|(gnt_reg & req_valid)) begin
               beat_acc = 1'b1;
               if (beat_reg == '0) begin
                  mode_next = req_mode[id_reg];
               end
               // The last beat launches operand 0 straight away, keeping the window contiguous.
               if (beat_reg == LAST_IDX) begin
                  gnt_next           = '0;
                  issue_next         = CNT_W'(1);
                  eng_in_valid_next  = 1'b1;
                  eng_in_number_next = buf_mem[rd_idx];
                  eng_mode_next      = mode_reg;
                  state_next         = ISSUE;
               end else begin
                  beat_next = beat_reg + 1'b1;
               end
            end
         end
         ISSUE: begin
            rd_idx             = issue_reg;
            eng_in_valid_next  = 1'b1;
            eng_in_number_next = buf_mem[rd_idx];
            if (issue_reg == LAST_IDX) begin
               state_next = WAIT;
            end else begin
               issue_next = issue_reg + 1'b1;
            end
         end
         WAIT: begin
            if (eng_out_valid) begin
               rsp_valid_next  = 1'b1;
               rsp_id_next     = id_reg;
               rsp_result_next = eng_out_result;
`ifdef CALC_SCHED_TIMEOUT_EN
               rsp_err_next    = 1'b0;
`endif
               state_next      = RESP;
            end
`ifdef CALC_SCHED_TIMEOUT_EN
            else if (wait_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1)) begin
               rsp_valid_next  = 1'b1;
               rsp_id_next     = id_reg;
               rsp_result_next = '0;
               rsp_err_next    = 1'b1;
               state_next      = RESP;
            end
`endif
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_next = 1'b0;
               arb_upd        = 1'b1;
               state_next     = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg         <= IDLE;
         gnt_reg           <= '0;
         id_reg            <= 1'b0;
         mode_reg          <= '0;
         beat_reg          <= '0;
         issue_reg         <= '0;
         eng_in_valid_reg  <= 1'b0;
         eng_in_number_reg <= '0;
         eng_mode_reg      <= '0;
         rsp_valid_reg     <= 1'b0;
         rsp_id_reg        <= 1'b0;
         rsp_result_reg    <= '0;
      end else begin
         state_reg         <= state_next;
         gnt_reg           <= gnt_next;
         id_reg            <= id_next;
         mode_reg          <= mode_next;
         beat_reg          <= beat_next;
         issue_reg         <= issue_next;
         eng_in_valid_reg  <= eng_in_valid_next;
         eng_in_number_reg <= eng_in_number_next;
         eng_mode_reg      <= eng_mode_next;
         rsp_valid_reg     <= rsp_valid_next;
         rsp_id_reg        <= rsp_id_next;
         rsp_result_reg    <= rsp_result_next;
      end
   end

`ifdef CALC_SCHED_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt_reg <= '0;
         rsp_err_reg  <= 1'b0;
      end else begin
         wait_cnt_reg <= wait_cnt_next;
         rsp_err_reg  <= rsp_err_next;
      end
   end
   assign rsp_err = rsp_err_reg;
`else
   assign rsp_err = 1'b0;
`endif

   assign gnt           = gnt_reg;
   assign eng_in_valid  = eng_in_valid_reg;
   assign eng_in_number = eng_in_number_reg;
   assign eng_mode      = eng_mode_reg;
   assign rsp_valid     = rsp_valid_reg;
   assign rsp_id        = rsp_id_reg;
   assign rsp_result    = rsp_result_reg;
endmodule

// File: tb/tb_calc_sched.sv
// tb_calc_sched: table-driven jobs plus hand sequences; a cycle-stepped requester/engine
// model feeds queues of expected grants, operands and responses that are checked as they appear.
`timescale 1ns/1ps
module tb_calc_sched;
   localparam int BL = 6;
   localparam int TO = 64;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic [1:0]       req_valid = '0;
   logic [1:0][1:0]  req_mode = '0;
   logic [1:0][3:0]  req_data = '0;
   logic [1:0]       gnt;
   logic             eng_in_valid;
   logic [3:0]       eng_in_number;
   logic [1:0]       eng_mode;
   logic             eng_out_valid = 1'b0;
   logic signed [6:0] eng_out_result = '0;
   logic             rsp_valid;
   logic             rsp_id;
   logic signed [6:0] rsp_result;
   logic             rsp_err;
   logic             rsp_ready = 1'b0;

   calc_sched #(.BURST_LEN(BL), .TIMEOUT_CYCLES(TO)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_mode       (req_mode),
      .req_data       (req_data),
      .gnt            (gnt),
      .eng_in_valid   (eng_in_valid),
      .eng_in_number  (eng_in_number),
      .eng_mode       (eng_mode),
      .eng_out_valid  (eng_out_valid),
      .eng_out_result (eng_out_result),
      .rsp_valid      (rsp_valid),
      .rsp_id         (rsp_id),
      .rsp_result     (rsp_result),
      .rsp_err        (rsp_err),
      .rsp_ready      (rsp_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        id;
      logic [1:0]  mode;
      logic [23:0] data;      // beat k in data[4k+:4]
      logic        gap;       // drop req_valid for 2 cycles after beat 3
      int          lat;       // engine latency after last operand, -1 = never
      logic [6:0]  eng_res;
      int          rdy;       // cycles rsp_ready held low after rsp_valid rises
      logic [1:0]  exp_gnt;
      logic        exp_id;
      logic [6:0]  exp_res;
      logic        exp_err;
   } vec_t;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [6:0] q0[$], q1[$];           // {gap, mode, data} beats still to send
   logic [6:0] exp_op[$];              // {first, mode, data}
   logic [1:0] exp_gnt_q[$];
   int         eng_lat_q[$];
   logic [6:0] eng_res_q[$];
   logic       exp_id_q[$];
   logic [6:0] exp_res_q[$];
   logic       exp_err_q[$];
   int         exp_rdy_q[$];

   int         hold0 = 0, hold1 = 0, rdy_hold = 0, in_burst = 0, eng_timer = 0, last_in_cyc = 0;
   logic [6:0] eng_res_cur = '0;
   logic       eov_real = 1'b0;
   logic [1:0] gnt_prev = '0;
   logic       held_id = 1'b0, held_err = 1'b0;
   logic [6:0] held_res = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic drive_req();
      logic [6:0] e;
      req_valid = '0;
      req_data  = '0;
      req_mode  = '0;
      if (q0.size() > 0) begin
         e = q0[0];
         req_data[0] = e[3:0];
         req_mode[0] = e[5:4];
         if (hold0 > 0) hold0--; else req_valid[0] = 1'b1;
      end
      if (q1.size() > 0) begin
         e = q1[0];
         req_data[1] = e[3:0];
         req_mode[1] = e[5:4];
         if (hold1 > 0) hold1--; else req_valid[1] = 1'b1;
      end
   endtask

   task automatic step();
      logic [1:0] gnt_b, rv_b;
      logic       rspv_b, rdy_b, eov_b;
      logic [6:0] e;
      int         lat;
      gnt_b  = gnt;
      rv_b   = req_valid;
      rspv_b = rsp_valid;
      rdy_b  = rsp_ready;
      eov_b  = eov_real;
      @(posedge clk);
      #1;
      cyc++;
      if (rst_n) begin
         if (gnt_b[0] && rv_b[0] && q0.size() > 0) begin
            e = q0.pop_front();
            if (e[6]) hold0 = 2;
         end
         if (gnt_b[1] && rv_b[1] && q1.size() > 0) begin
            e = q1.pop_front();
            if (e[6]) hold1 = 2;
         end
      end
      eng_out_valid = 1'b0;
      eov_real      = 1'b0;
      if (eng_timer > 0) begin
         eng_timer--;
         if (eng_timer == 0) begin
            eng_out_valid  = 1'b1;
            eng_out_result = eng_res_cur;
            eov_real       = 1'b1;
         end
      end
      if (gnt != 2'b00 && gnt_prev == 2'b00) begin
         if (exp_gnt_q.size() == 0) chk("gnt_unexpected", 32'(gnt), 32'(0));
         else chk("gnt_order", 32'(gnt), 32'(exp_gnt_q.pop_front()));
      end
      gnt_prev = gnt;
      if (eng_in_valid) begin
         if (exp_op.size() == 0) begin
            chk("op_unexpected", 32'(1), 32'(0));
         end else begin
            e = exp_op.pop_front();
            chk("op_data", 32'(eng_in_number), 32'(e[3:0]));
            chk("op_mode", 32'(eng_mode), 32'(e[6] ? e[5:4] : 2'b00));
         end
         in_burst++;
         last_in_cyc = cyc;
         if (in_burst == BL) begin
            in_burst = 0;
            if (eng_lat_q.size() > 0) begin
               lat = eng_lat_q.pop_front();
               e   = eng_res_q.pop_front();
               if (lat > 0) begin
                  eng_timer   = lat;
                  eng_res_cur = e;
               end
            end
         end
      end else if (in_burst != 0) begin
         chk("op_contiguous", 32'(0), 32'(1));
         in_burst = 0;
      end
      if (eov_b) chk("rsp_latency", 32'(rsp_valid), 32'(1));
      if (rspv_b && rdy_b) begin
         chk("rsp_drop", 32'(rsp_valid), 32'(0));
      end else if (rspv_b) begin
         chk("rsp_hold", 32'({rsp_valid, rsp_id, rsp_err, rsp_result}),
             32'({1'b1, held_id, held_err, held_res}));
      end else if (rsp_valid) begin
         $display("rsp id=%0d result=%0d err=%0d cycle=%0d", rsp_id, rsp_result, rsp_err, cyc);
         if (exp_id_q.size() == 0) begin
            chk("rsp_unexpected", 32'(1), 32'(0));
         end else begin
            chk("rsp_id", 32'(rsp_id), 32'(exp_id_q.pop_front()));
            chk("rsp_result", 32'({rsp_result}), 32'(exp_res_q[0]));
            chk("rsp_err", 32'(rsp_err), 32'(exp_err_q[0]));
            if (exp_err_q[0]) chk("timeout_delay", 32'(cyc - last_in_cyc), 32'(TO));
            void'(exp_res_q.pop_front());
            void'(exp_err_q.pop_front());
            rdy_hold = exp_rdy_q.pop_front();
         end
         held_id  = rsp_id;
         held_err = rsp_err;
         held_res = rsp_result;
      end
      if (rsp_valid) begin
         if (rdy_hold > 0) begin
            rsp_ready = 1'b0;
            rdy_hold--;
         end else begin
            rsp_ready = 1'b1;
         end
      end else begin
         rsp_ready = cyc[0];
      end
      drive_req();
   endtask

   task automatic add_job(input logic id, input logic [1:0] mode, input logic [23:0] data,
                          input logic gap, input int lat, input logic [6:0] eng_res,
                          input int rdy, input bit push_rsp, input logic [1:0] exp_gnt,
                          input logic exp_id, input logic [6:0] exp_res, input logic exp_err);
      logic [6:0] e;
      for (int k = 0; k < BL; k++) begin
         e = {gap && (k == 3), mode, data[4*k +: 4]};
         if (id) q1.push_back(e); else q0.push_back(e);
         exp_op.push_back({k == 0, mode, data[4*k +: 4]});
      end
      exp_gnt_q.push_back(exp_gnt);
      eng_lat_q.push_back(lat);
      eng_res_q.push_back(eng_res);
      if (push_rsp) begin
         exp_id_q.push_back(exp_id);
         exp_res_q.push_back(exp_res);
         exp_err_q.push_back(exp_err);
         exp_rdy_q.push_back(rdy);
      end
      drive_req();
   endtask

   task automatic drain(input int max_cyc);
      int n;
      n = 0;
      while ((q0.size() > 0 || q1.size() > 0 || exp_id_q.size() > 0 || rsp_valid) && n < max_cyc) begin
         step();
         n++;
      end
      if (n >= max_cyc) chk("drain_timeout", 32'(n), 32'(0));
   endtask

   task automatic flush();
      q0.delete(); q1.delete(); exp_op.delete(); exp_gnt_q.delete();
      eng_lat_q.delete(); eng_res_q.delete();
      exp_id_q.delete(); exp_res_q.delete(); exp_err_q.delete(); exp_rdy_q.delete();
      hold0 = 0; hold1 = 0; rdy_hold = 0; in_burst = 0; eng_timer = 0;
      eov_real = 1'b0; gnt_prev = '0;
      eng_out_valid = 1'b0; rsp_ready = 1'b0;
      drive_req();
   endtask

   task automatic do_reset(input bit check_now);
      rst_n = 1'b0;
      flush();
      #1;
      if (check_now)
         chk("reset_outputs", 32'({gnt, eng_in_valid, eng_in_number, eng_mode,
                                   rsp_valid, rsp_id, rsp_result, rsp_err}), 32'(0));
      step();
      step();
      rst_n = 1'b1;
   endtask

   vec_t vecs[4];

   initial begin
      vecs[0] = '{id: 1'b0, mode: 2'd2, data: {4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1}, gap: 1'b0,
                  lat: 3, eng_res: 7'd21, rdy: 0, exp_gnt: 2'b01, exp_id: 1'b0,
                  exp_res: 7'd21, exp_err: 1'b0};
      vecs[1] = '{id: 1'b1, mode: 2'd1, data: {4'd12, 4'd11, 4'd10, 4'd7, 4'd8, 4'd9}, gap: 1'b1,
                  lat: 1, eng_res: 7'h7B, rdy: 1, exp_gnt: 2'b10, exp_id: 1'b1,
                  exp_res: 7'h7B, exp_err: 1'b0};
      vecs[2] = '{id: 1'b0, mode: 2'd3, data: {4'd2, 4'd13, 4'd1, 4'd14, 4'd0, 4'd15}, gap: 1'b0,
                  lat: 5, eng_res: 7'h40, rdy: 0, exp_gnt: 2'b01, exp_id: 1'b0,
                  exp_res: 7'b1000000, exp_err: 1'b0};
      vecs[3] = '{id: 1'b1, mode: 2'd0, data: {4'd3, 4'd3, 4'd9, 4'd0, 4'd15, 4'd5}, gap: 1'b0,
                  lat: 2, eng_res: 7'd63, rdy: 2, exp_gnt: 2'b10, exp_id: 1'b1,
                  exp_res: 7'd63, exp_err: 1'b0};

      #2;
      do_reset(1'b1);

      // Stray engine strobe while idle must not produce a response.
      eng_out_valid  = 1'b1;
      eng_out_result = 7'sd33;
      step();
      chk("stray_eov_ignored", 32'(rsp_valid), 32'(0));

      for (int v = 0; v < 4; v++) begin
         add_job(vecs[v].id, vecs[v].mode, vecs[v].data, vecs[v].gap, vecs[v].lat,
                 vecs[v].eng_res, vecs[v].rdy, 1'b1, vecs[v].exp_gnt, vecs[v].exp_id,
                 vecs[v].exp_res, vecs[v].exp_err);
         step();
         chk("gnt_latency", 32'(gnt), 32'(vecs[v].exp_gnt));
         drain(400);
      end

      // Contention from reset: order 0,1,0 with the first response held for 5 cycles.
      do_reset(1'b0);
      add_job(1'b0, 2'd1, {4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3}, 1'b0, 2, 7'd10, 5, 1'b1,
              2'b01, 1'b0, 7'd10, 1'b0);
      add_job(1'b1, 2'd2, {4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3}, 1'b0, 3, 7'h70, 0, 1'b1,
              2'b10, 1'b1, 7'h70, 1'b0);
      add_job(1'b0, 2'd3, {4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10}, 1'b0, 4, 7'd5, 0, 1'b1,
              2'b01, 1'b0, 7'd5, 1'b0);
      drain(800);

      // Engine never answers.
`ifdef CALC_SCHED_TIMEOUT_EN
      add_job(1'b0, 2'd1, {4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1}, 1'b0, -1, 7'd0, 0, 1'b1,
              2'b01, 1'b0, 7'd0, 1'b1);
      drain(300);
`else
      begin
         int seen;
         add_job(1'b0, 2'd1, {4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1}, 1'b0, -1, 7'd0, 0, 1'b0,
                 2'b01, 1'b0, 7'd0, 1'b0);
         drain(100);
         seen = 0;
         for (int i = 0; i < 200; i++) begin
            step();
            if (rsp_valid) seen++;
         end
         chk("no_rsp_without_timeout", 32'(seen), 32'(0));
         do_reset(1'b0);
      end
`endif

      // Reset in the middle of ISSUE, then a fresh req1 job.
      begin
         int n;
         add_job(1'b0, 2'd2, {4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9}, 1'b0, 3, 7'd1, 0, 1'b1,
                 2'b01, 1'b0, 7'd1, 1'b0);
         n = 0;
         while (in_burst != 3 && n < 60) begin
            step();
            n++;
         end
         chk("reach_mid_issue", 32'(in_burst), 32'(3));
         do_reset(1'b1);
         add_job(1'b1, 2'd3, {4'd1, 4'd2, 4'd4, 4'd8, 4'd15, 4'd0}, 1'b0, 2, 7'h55, 0, 1'b1,
                 2'b10, 1'b1, 7'h55, 1'b0);
         step();
         chk("gnt_after_reset", 32'(gnt), 32'(2'b10));
         drain(400);
      end

      chk("queues_empty", 32'(exp_op.size() + exp_gnt_q.size() + exp_id_q.size()), 32'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/calc_sched.md
# calc_sched

Round-robin scheduler that shares one nibble-stream arithmetic engine between two requesters. It grants one requester at a time and buffers that requester's burst of 4-bit operands. It replays the burst to the engine as one contiguous valid window, then returns the engine's signed 7-bit result to the granted requester over a valid/ready response channel. It sits between the requester logic and the engine instance in the lab top level.

## Interface
- BURST_LEN, 6, operands per job; legal range 2..15.
- TIMEOUT_CYCLES, 64, WAIT-state watchdog limit; used only with the timeout macro.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  bit i high: requester i presents an operand beat.
- req_mode  in  2x2  mode from requester i; sampled on its first accepted beat.
- req_data  in  2x4  operand from requester i.
- gnt  out  2  one-hot grant; a beat from requester i is accepted when gnt[i] and req_valid[i] are both high in LOAD.
- eng_in_valid  out  1  engine input valid.
- eng_in_number  out  4  engine operand.
- eng_mode  out  2  engine mode; meaningful on the first eng_in_valid cycle, 0 otherwise.
- eng_out_valid  in  1  engine result strobe (1-cycle pulse).
- eng_out_result  in  7 signed  engine result.
- rsp_valid  out  1  response valid.
- rsp_id  out  1  requester that owns the response.
- rsp_result  out  7 signed  captured result.
- rsp_err  out  1  timeout response flag.
- rsp_ready  in  1  response accepted.

## Operation
- FSM states: IDLE, LOAD, ISSUE, WAIT, RESP.
- IDLE, when any req_valid bit is high:
  - Arbitrate round-robin: priority goes to the requester after the last one served; after reset, requester 0 has priority.
  - Register gnt and go to LOAD next cycle.
- LOAD:
  - Accept beats while gnt[g] and req_valid[g] are high; gaps are allowed.
  - Store beats in a BURST_LEN x 4 buffer, in order.
  - Latch req_mode[g] on beat 0.
  - After beat BURST_LEN-1: gnt goes to 0 and the FSM goes to ISSUE.
  - The other requester's req_valid is ignored throughout LOAD.
- ISSUE:
  - eng_in_valid is high for exactly BURST_LEN consecutive cycles, buffer[0..BURST_LEN-1] in order.
  - eng_mode carries the latched mode on cycle 0 only.
  - Then go to WAIT.
- WAIT:
  - The first eng_out_valid captures eng_out_result into rsp_result, clears rsp_err, and moves to RESP.
- RESP:
  - rsp_valid, rsp_id, rsp_result and rsp_err are held stable until rsp_ready.
  - When rsp_valid and rsp_ready are both high: update the priority pointer, drop rsp_valid, go to IDLE.
- eng_out_valid outside WAIT is ignored; no capture, no state change.
- Results are passed through unmodified; no arithmetic on data.
- If both requesters are valid in IDLE, the pointer decides; no requester is served twice in a row while the other waits.

## Timing
- Reset (async assert, sync release): state IDLE; pointer to requester 0.
- All outputs reset to 0: gnt, eng_in_valid, eng_in_number, eng_mode, rsp_valid, rsp_id, rsp_result, rsp_err.
- All outputs are registered.
- IDLE request seen at cycle t: gnt is high at t+1; the earliest accepted beat is at t+1.
- Last beat accepted at cycle c: eng_in_valid is high for cycles c+1 .. c+BURST_LEN.
- eng_out_valid at cycle r in WAIT: rsp_valid is high from r+1.
- Handshake at cycle h: rsp_valid is low at h+1; a new gnt can appear at h+2.
- Minimum job turnaround: 2·BURST_LEN + engine latency + 3 cycles.
- Reset asserted mid-operation aborts the job. The buffered burst is discarded and no response is produced.
- rsp_ready high outside RESP has no effect.

## Configuration
- CALC_SCHED_TIMEOUT_EN defined:
  - WAIT counts cycles from entry.
  - At count TIMEOUT_CYCLES with no eng_out_valid, go to RESP with rsp_err=1 and rsp_result=0.
  - An eng_out_valid in the same cycle as expiry wins, giving a normal response.
- Not defined: no counter; WAIT waits indefinitely and rsp_err is tied to 0.

## Structure
- Package calc_sched_pkg holds:
  - state enum sched_state_e;
  - NUM_W=4, MODE_W=2, RES_W=7, NUM_REQ=2 constants.
- Sub-module rr_arb2: 2-way round-robin arbiter.
  - Inputs: request vector, pointer update strobe.
  - Output: one-hot grant.
- FSM, burst buffer, issue counter and watchdog live in calc_sched.

## Test plan
- Single job, defaults: req0 mode=2, data 1,2,3,4,5,6 back-to-back; engine returns 7'sd21 three cycles after the last input. Expect eng_in_valid for 6 contiguous cycles with operands 1..6, eng_mode=2 on the first cycle only, then rsp_id=0, rsp_result=21, rsp_err=0.
- Gapped load: req1 drops req_valid for 2 cycles between beats 3 and 4. Expect eng_in_valid still contiguous for 6 cycles, rsp_id=1.
- Contention: both requesters valid from reset. Expect the order req0, req1, req0. Hold rsp_ready low for 5 cycles and check the response is held stable.
- Negative result: engine returns -7'sd64. Expect rsp_result=7'b1000000.
- Timeout (CALC_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=64): engine never responds. Expect rsp_err=1 and rsp_result=0 exactly 64 cycles after WAIT entry. Without the macro: no response after 200 cycles.
- Reset mid-ISSUE after 3 operands: expect all outputs 0 immediately. A fresh req1 job completes normally afterwards.
